// File: rtl/uart_rx_fifo_if.sv
// Valid/ready receive handshake between uart_rx_fifo (master) and the CPU load path (slave).
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with configurable framing and a first-word-fall-through FIFO.
// Optional break detection is enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_fifo #(
    parameter int BAUD_DIV    = 651,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx,
    uart_rx_fifo_if.master              rx_bus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        frame_err,
    output logic                        parity_err,
`ifdef UART_RX_BREAK_DET_EN
    output logic                        break_det,
`endif
    output logic                        overrun
);
    localparam int TW  = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_BITS);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    state_t               state_q, state_d;
    logic                 sync_q, sync_d;
    logic                 rx_s_q, rx_s_d;
    logic                 rx_prev_q, rx_prev_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [OSW-1:0]       os_cnt_q, os_cnt_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bad_q, par_bad_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [DATA_BITS-1:0] head_q, head_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
`ifdef UART_RX_BREAK_DET_EN
    logic                 brk_hold_q, brk_hold_d;
    logic                 line_low_q, line_low_d;
    logic                 break_q, break_d;
`endif

    logic          tick;
    logic          start_ok;
    logic          push;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic [PW-1:0] rd_next;

    always_comb begin
        sync_d       = rx;
        rx_s_d       = sync_q;
        rx_prev_d    = rx_s_q;
        tick         = (tick_cnt_q == TW'(BAUD_DIV - 1));
        tick_cnt_d   = tick ? '0 : tick_cnt_q + 1'b1;
        os_cnt_d     = tick ? os_cnt_q + 1'b1 : os_cnt_q;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_bad_d    = par_bad_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        push         = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        // After a break, new starts are blocked until the line has returned high.
        start_ok     = !brk_hold_q;
        brk_hold_d   = rx_s_q ? 1'b0 : brk_hold_q;
        line_low_d   = line_low_q;
        break_d      = 1'b0;
`else
        start_ok     = 1'b1;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start_ok && rx_prev_q && !rx_s_q) begin
                    state_d    = ST_START;
                    tick_cnt_d = '0;
                    os_cnt_d   = '0;
                end
            end
            ST_START: begin
                if (tick && os_cnt_q == OSW'(OVERSAMPLE / 2 - 1)) begin
                    os_cnt_d  = '0;
                    bit_cnt_d = '0;
                    par_bad_d = 1'b0;
                    state_d   = rx_s_q ? ST_IDLE : ST_DATA;
`ifdef UART_RX_BREAK_DET_EN
                    line_low_d = 1'b1;
`endif
                end
            end
            ST_DATA: begin
                if (tick && os_cnt_q == OSW'(OVERSAMPLE - 1)) begin
                    os_cnt_d = '0;
                    shift_d  = {rx_s_q, shift_q[DATA_BITS-1:1]};
`ifdef UART_RX_BREAK_DET_EN
                    if (rx_s_q) line_low_d = 1'b0;
`endif
                    if (bit_cnt_q == BCW'(DATA_BITS - 1))
                        state_d = (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
                    else
                        bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (tick && os_cnt_q == OSW'(OVERSAMPLE - 1)) begin
                    os_cnt_d  = '0;
                    // Even parity wants XOR(data, p) = 0, odd wants 1.
                    par_bad_d = (^shift_q) ^ rx_s_q ^ (PARITY_MODE == 2);
                    state_d   = ST_STOP;
`ifdef UART_RX_BREAK_DET_EN
                    if (rx_s_q) line_low_d = 1'b0;
`endif
                end
            end
            ST_STOP: begin
                if (tick && os_cnt_q == OSW'(OVERSAMPLE - 1)) begin
                    os_cnt_d = '0;
                    state_d  = ST_IDLE;
                    if (!rx_s_q) begin
`ifdef UART_RX_BREAK_DET_EN
                        if (line_low_q) begin
                            break_d    = 1'b1;
                            brk_hold_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
`else
                        frame_err_d = 1'b1;
`endif
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A full FIFO still accepts a push when the head leaves in the same cycle.
        pop       = (count_q != '0) && rx_bus.rx_ready;
        full      = (count_q == CW'(FIFO_DEPTH));
        wr_en     = push && (!full || pop);
        overrun_d = push && full && !pop;
        count_d   = count_q + CW'(wr_en) - CW'(pop);
        wr_ptr_d  = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_next   = rd_ptr_q + 1'b1;
        rd_ptr_d  = pop ? rd_next : rd_ptr_q;
        head_d    = head_q;
        if (pop && count_q > CW'(1))
            head_d = mem_q[rd_next];
        else if (wr_en && (count_q == '0 || (pop && count_q == CW'(1))))
            head_d = shift_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            sync_q       <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b1;
            tick_cnt_q   <= '0;
            os_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_q       <= '0;
`ifdef UART_RX_BREAK_DET_EN
            brk_hold_q   <= 1'b0;
            line_low_q   <= 1'b0;
            break_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            rx_s_q       <= rx_s_d;
            rx_prev_q    <= rx_prev_d;
            tick_cnt_q   <= tick_cnt_d;
            os_cnt_q     <= os_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_q       <= head_d;
`ifdef UART_RX_BREAK_DET_EN
            brk_hold_q   <= brk_hold_d;
            line_low_q   <= line_low_d;
            break_q      <= break_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= shift_q;
    end

    assign rx_bus.rx_data  = head_q;
    assign rx_bus.rx_valid = (count_q != '0);
    assign fifo_count      = count_q;
    assign frame_err       = frame_err_q;
    assign parity_err      = parity_err_q;
    assign overrun         = overrun_q;
`ifdef UART_RX_BREAK_DET_EN
    assign break_det       = break_q;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised and directed checks of uart_rx_fifo: one instance per parity mode, each against a frame-level queue model.
module tb_uart_rx_fifo;
    localparam int BD  = 2;
    localparam int OS  = 16;
    localparam int DB  = 8;
    localparam int FD  = 4;
    localparam int BIT = BD * OS;
    localparam int NCH = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          rx_line [NCH];
    logic          ready_r [NCH];
    logic [DB-1:0] data_w  [NCH];
    logic          valid_w [NCH];
    logic [2:0]    cnt_w   [NCH];
    logic          fe_w    [NCH];
    logic          pe_w    [NCH];
    logic          ov_w    [NCH];
`ifdef UART_RX_BREAK_DET_EN
    logic          brk_w   [NCH];
`endif

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        uart_rx_fifo_if #(.DATA_BITS(DB)) bus_i ();
        assign bus_i.rx_ready = ready_r[gi];
        assign data_w[gi]     = bus_i.rx_data;
        assign valid_w[gi]    = bus_i.rx_valid;
        uart_rx_fifo #(
            .BAUD_DIV(BD), .OVERSAMPLE(OS), .DATA_BITS(DB),
            .PARITY_MODE(gi), .FIFO_DEPTH(FD)
        ) dut (
            .clk(clk),
            .reset(reset),
            .rx(rx_line[gi]),
            .rx_bus(bus_i),
            .fifo_count(cnt_w[gi]),
            .frame_err(fe_w[gi]),
            .parity_err(pe_w[gi]),
`ifdef UART_RX_BREAK_DET_EN
            .break_det(brk_w[gi]),
`endif
            .overrun(ov_w[gi])
        );
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Frame-level model: expected outcome of each frame lands on its stop-sample cycle.
    int          ev_cyc  [NCH];
    int          ev_kind [NCH];   // 0 none, 1 push, 2 frame error, 3 parity error
    logic [7:0]  ev_byte [NCH];
    logic [7:0]  mq      [NCH][FD];
    int          mcnt    [NCH];
    logic [7:0]  mhead   [NCH];
    logic        e_fe    [NCH];
    logic        e_pe    [NCH];
    logic        e_ov    [NCH];
    int          fe_seen [NCH];
    int          pe_seen [NCH];
    int          ov_seen [NCH];
    logic        rnd_en  [NCH];

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s ch%0d: got 0x%0h expected 0x%0h (cycle %0d)", nm, c, act, exp, cyc);
        end
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) begin
            ev_kind[c] = 0; ev_cyc[c] = 0; ev_byte[c] = 8'h00; mcnt[c] = 0; mhead[c] = 8'h00;
            e_fe[c] = 1'b0; e_pe[c] = 1'b0; e_ov[c] = 1'b0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int c = 0; c < NCH; c++) begin
                e_fe[c] = 1'b0; e_pe[c] = 1'b0; e_ov[c] = 1'b0;
                if (!reset) begin
                    mcnt[c] = 0; mhead[c] = 8'h00; ev_kind[c] = 0;
                end else begin
                    if (mcnt[c] > 0 && ready_r[c]) begin
                        for (int k = 0; k < FD - 1; k++) mq[c][k] = mq[c][k+1];
                        mcnt[c]--;
                    end
                    if (ev_kind[c] != 0 && cyc == ev_cyc[c]) begin
                        case (ev_kind[c])
                            1: if (mcnt[c] == FD) e_ov[c] = 1'b1;
                               else begin mq[c][mcnt[c]] = ev_byte[c]; mcnt[c]++; end
                            2: e_fe[c] = 1'b1;
                            default: e_pe[c] = 1'b1;
                        endcase
                        ev_kind[c] = 0;
                    end
                    if (mcnt[c] > 0) mhead[c] = mq[c][0];
                end
            end
        end
    end

    initial begin
        for (int c = 0; c < NCH; c++) begin fe_seen[c] = 0; pe_seen[c] = 0; ov_seen[c] = 0; end
        forever begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                if (fe_w[c]) fe_seen[c]++;
                if (pe_w[c]) pe_seen[c]++;
                if (ov_w[c]) ov_seen[c]++;
                if (!reset) begin
                    chk("reset_valid", c, 32'(valid_w[c]), 0);
                    chk("reset_count", c, 32'(cnt_w[c]), 0);
                    chk("reset_data", c, 32'(data_w[c]), 0);
                    chk("reset_pulses", c, {29'd0, fe_w[c], pe_w[c], ov_w[c]}, 0);
                end else begin
                    chk("rx_valid", c, 32'(valid_w[c]), 32'(mcnt[c] > 0));
                    chk("fifo_count", c, 32'(cnt_w[c]), 32'(mcnt[c]));
                    chk("rx_data", c, 32'(data_w[c]), 32'(mhead[c]));
                    chk("frame_err", c, 32'(fe_w[c]), 32'(e_fe[c]));
                    chk("parity_err", c, 32'(pe_w[c]), 32'(e_pe[c]));
                    chk("overrun", c, 32'(ov_w[c]), 32'(e_ov[c]));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int c = 0; c < NCH; c++)
                if (rnd_en[c]) ready_r[c] = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Channel c runs PARITY_MODE=c; pflip inverts the correct parity bit.
    task automatic send_frame(input int c, input logic [7:0] d, input logic stopb, input logic pflip);
        logic [10:0] fr;
        int nb;
        int np;
        np = (c != 0) ? 1 : 0;
        fr = '1;
        fr[0] = 1'b0;
        fr[8:1] = d;
        if (np == 1) begin
            fr[9]  = (^d) ^ (c == 2) ^ pflip;
            fr[10] = stopb;
            nb = 11;
        end else begin
            fr[9] = stopb;
            nb = 10;
        end
        @(posedge clk);
        #1;
        // 2 sync flops + edge register, half a bit to mid start, then one bit per remaining sample.
        ev_cyc[c]  = cyc + 3 + BIT / 2 + BIT * (DB + np + 1);
        ev_byte[c] = d;
        ev_kind[c] = !stopb ? 2 : ((np == 1 && pflip) ? 3 : 1);
        $display("frame ch%0d data=0x%02h stop=%0d parity_flip=%0d kind=%0d", c, d, stopb, pflip, ev_kind[c]);
        for (int i = 0; i < nb; i++) begin
            rx_line[c] = fr[i];
            repeat (BIT) @(posedge clk);
            #1;
        end
        rx_line[c] = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int base_fe, base_pe, base_ov, t;

    initial begin
        reset = 1'b0;
        for (int c = 0; c < NCH; c++) begin rx_line[c] = 1'b1; ready_r[c] = 1'b0; rnd_en[c] = 1'b0; end
        idle(5);
        reset = 1'b1;
        idle(8);

        send_frame(0, 8'h49, 1'b1, 1'b0);
        chk("lit_49_valid", 0, 32'(valid_w[0]), 1);
        chk("lit_49_data", 0, 32'(data_w[0]), 32'h49);
        chk("lit_49_count", 0, 32'(cnt_w[0]), 1);
        ready_r[0] = 1'b1;
        idle(1);
        ready_r[0] = 1'b0;
        idle(1);
        chk("lit_pop_valid", 0, 32'(valid_w[0]), 0);

        base_fe = fe_seen[0]; base_pe = pe_seen[0];
        rx_line[0] = 1'b0;
        idle(10);
        rx_line[0] = 1'b1;
        idle(2 * BIT);
        chk("lit_glitch_pulses", 0, 32'(fe_seen[0] - base_fe + pe_seen[0] - base_pe), 0);
        chk("lit_glitch_count", 0, 32'(cnt_w[0]), 0);

        base_fe = fe_seen[0];
        send_frame(0, 8'h12, 1'b0, 1'b0);
        idle(BIT);
        chk("lit_frame_err_once", 0, 32'(fe_seen[0] - base_fe), 1);
        chk("lit_frame_err_count", 0, 32'(cnt_w[0]), 0);

        base_pe = pe_seen[1];
        send_frame(1, 8'h03, 1'b1, 1'b1);
        chk("lit_parity_err_once", 1, 32'(pe_seen[1] - base_pe), 1);
        chk("lit_parity_count", 1, 32'(cnt_w[1]), 0);

        base_ov = ov_seen[0];
        for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b1, 1'b0);
        chk("lit_overrun_once", 0, 32'(ov_seen[0] - base_ov), 1);
        chk("lit_full_count", 0, 32'(cnt_w[0]), 4);
        chk("lit_full_head", 0, 32'(data_w[0]), 32'h01);
        ready_r[0] = 1'b1;
        idle(8);
        ready_r[0] = 1'b0;
        chk("lit_drained", 0, 32'(cnt_w[0]), 0);

        for (int i = 1; i <= 4; i++) send_frame(0, 8'(i), 1'b1, 1'b0);
        base_ov = ov_seen[0];
        fork
            send_frame(0, 8'h06, 1'b1, 1'b0);
            begin
                @(posedge clk);
                #2;
                t = ev_cyc[0];
                while (cyc != t - 1) begin @(posedge clk); #1; end
                ready_r[0] = 1'b1;
                @(posedge clk);
                #1;
                ready_r[0] = 1'b0;
            end
        join
        chk("lit_full_pushpop_count", 0, 32'(cnt_w[0]), 4);
        chk("lit_full_pushpop_head", 0, 32'(data_w[0]), 32'h02);
        chk("lit_full_pushpop_no_ov", 0, 32'(ov_seen[0] - base_ov), 0);

        rx_line[0] = 1'b0;
        idle(3 * BIT);
        reset = 1'b0;
        rx_line[0] = 1'b1;
        idle(4);
        reset = 1'b1;
        idle(12 * BIT);
        chk("lit_reset_mid_count", 0, 32'(cnt_w[0]), 0);
        send_frame(0, 8'hA5, 1'b1, 1'b0);
        chk("lit_after_reset_data", 0, 32'(data_w[0]), 32'hA5);
        ready_r[0] = 1'b1;
        idle(2);
        ready_r[0] = 1'b0;

        for (int c = 0; c < NCH; c++) begin
            rnd_en[c] = 1'b1;
            for (int n = 0; n < 10; n++) begin
                logic [7:0] d;
                logic       sb;
                logic       pf;
                d  = 8'($urandom);
                sb = ($urandom_range(0, 7) != 0);
                if (!sb) d = d | 8'h01;
                pf = (c != 0) && ($urandom_range(0, 5) == 0);
                send_frame(c, d, sb, pf);
            end
            rnd_en[c] = 1'b0;
            ready_r[c] = 1'b1;
            idle(10);
            ready_r[c] = 1'b0;
            chk("rand_drained", c, 32'(cnt_w[c]), 0);
        end

        idle(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
